// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32I core: sequences fetch, decode, execute and
// writeback over a shared memory and ALU, with a memory-ready handshake and illegal-op trap.
module multicycle_ctrl #(
  parameter bit EN_JALR         = 1'b1,
  parameter bit EN_AUIPC        = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  // An unsupported opcode either parks in TRAP or retires from DECODE as a nop.
  localparam state_e ILL_NEXT   = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
  localparam logic   ILL_RETIRE = !HALT_ON_ILLEGAL;

  state_e     state_q, state_d;
  logic       pc_update_s, branch_s, adr_src_s, ir_write_s, mem_write_s, reg_write_s;
  logic       retire_s, illegal_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d      = state_q;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          OP_JALR: begin
            state_d  = EN_JALR ? S_JALRADR : ILL_NEXT;
            retire_s = EN_JALR ? 1'b0 : ILL_RETIRE;
          end
          OP_AUIPC: begin
            state_d  = EN_AUIPC ? S_ALUWB : ILL_NEXT;
            retire_s = EN_AUIPC ? 1'b0 : ILL_RETIRE;
          end
          OP_NOP: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end
          default: begin
            state_d  = ILL_NEXT;
            retire_s = ILL_RETIRE;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        state_d     = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = mem_ready;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        state_d     = S_JAL;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:            ImmSrc = 3'b001;
      OP_BEQ:           ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Enables are forced low as soon as reset_n falls, so no write completes during reset.
  assign PCWrite   = reset_n & (pc_update_s | (branch_s & Zero));
  assign IRWrite   = reset_n & ir_write_s;
  assign MemWrite  = reset_n & mem_write_s;
  assign RegWrite  = reset_n & reg_write_s;
  assign retire    = reset_n & retire_s;
  assign illegal   = reset_n & illegal_s;
  assign AdrSrc    = adr_src_s;
  assign ResultSrc = result_src_s;
  assign ALUSrcA   = alu_src_a_s;
  assign ALUSrcB   = alu_src_b_s;
  assign ALUOp     = alu_op_s;

endmodule
